// File: rtl/mem_ctrl_mc_if.sv
// Bundle of configuration and load-request signals for the multi-channel load
// controller. The master modport is the host side and the slave modport is the controller side.
interface mem_ctrl_mc_if #(
  parameter int NUM_CHAN = 2,
  parameter int ADDR_W   = 64,
  parameter int CHAN_W   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
);
  logic                conf_valid;
  logic [CHAN_W-1:0]   conf_chan;
  logic [7:0]          conf_addr;
  logic [63:0]         conf_data;
  logic                conf_err;
  logic                load_req_valid;
  logic                load_req_ready;
  logic [ADDR_W-1:0]   load_req_addr;
  logic [CHAN_W-1:0]   load_req_chan;
  logic [NUM_CHAN-1:0] chan_busy;
  logic [NUM_CHAN-1:0] chan_done;

  modport master (
    output conf_valid, conf_chan, conf_addr, conf_data, load_req_ready,
    input  conf_err, load_req_valid, load_req_addr, load_req_chan, chan_busy, chan_done
  );

  modport slave (
    input  conf_valid, conf_chan, conf_addr, conf_data, load_req_ready,
    output conf_err, load_req_valid, load_req_addr, load_req_chan, chan_busy, chan_done
  );
endinterface

// File: rtl/mem_ctrl_mc.sv
// Multi-channel line-granular load request generator with a round-robin arbiter.
// Optional feature macro MEM_CTRL_ABORT_EN enables the ADDR_ABORT (0x18) register.
module mem_ctrl_mc #(
  parameter int NUM_CHAN   = 2,
  parameter int ADDR_W     = 64,
  parameter int SIZE_W     = 32,
  parameter int LINE_BYTES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_ctrl_mc_if.slave bus
);
  localparam int CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int LB_SH  = $clog2(LINE_BYTES);
  localparam int CNT_W  = SIZE_W - LB_SH + 1;
  localparam logic [CHAN_W:0] NUM_CHAN_L = (CHAN_W+1)'(NUM_CHAN);
  localparam logic [7:0] ADDR_BASE  = 8'h00;
  localparam logic [7:0] ADDR_SIZE  = 8'h08;
  localparam logic [7:0] ADDR_FIRE  = 8'h10;
  localparam logic [7:0] ADDR_ABORT = 8'h18;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  state_e              state_q [NUM_CHAN];
  logic [ADDR_W-1:0]   base_q  [NUM_CHAN];
  logic [ADDR_W-1:0]   ptr_q   [NUM_CHAN];
  logic [SIZE_W-1:0]   size_q  [NUM_CHAN];
  logic [CNT_W-1:0]    lines_q [NUM_CHAN];
  logic [CNT_W-1:0]    iss_q   [NUM_CHAN];
  logic [NUM_CHAN-1:0] abort_pend_q;
  logic [NUM_CHAN-1:0] done_q;
  logic [CHAN_W-1:0]   rr_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q;
  logic                last_q;
  logic                conf_err_q;

  logic                tgt_ok_s, tgt_busy_s, tgt_size0_s;
  logic                op_base_s, op_size_s, op_fire_s, op_abort_s, rej_s;
  logic [ADDR_W-1:0]   base_in_s;
  logic [NUM_CHAN-1:0] elig_s;
  logic [NUM_CHAN-1:0] busy_s;
  logic [CHAN_W-1:0]   idx_s;
  logic [CHAN_W-1:0]   grant_s;
  logic                grant_vld_s;
  logic                accept_s;
  logic                issue_s;

  // Number of lines covered by a byte count, rounded up.
  function automatic logic [CNT_W-1:0] line_count(input logic [SIZE_W-1:0] size);
    logic [SIZE_W:0] sum;
    sum = {1'b0, size} + (SIZE_W+1)'(LINE_BYTES - 1);
    return sum[SIZE_W:LB_SH];
  endfunction

  // Decode the configuration write against the target channel's current state.
  always_comb begin
    tgt_ok_s    = ({1'b0, bus.conf_chan} < NUM_CHAN_L);
    tgt_busy_s  = 1'b0;
    tgt_size0_s = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      tgt_busy_s  = tgt_busy_s  | ((bus.conf_chan == CHAN_W'(i)) && (state_q[i] == S_REQ));
      tgt_size0_s = tgt_size0_s | ((bus.conf_chan == CHAN_W'(i)) && (size_q[i] == '0));
    end
    base_in_s  = {bus.conf_data[ADDR_W-1:LB_SH], {LB_SH{1'b0}}};
    op_base_s  = 1'b0;
    op_size_s  = 1'b0;
    op_fire_s  = 1'b0;
    op_abort_s = 1'b0;
    rej_s      = 1'b0;
    if (!bus.conf_valid) begin
      rej_s = 1'b0;
    end else if (!tgt_ok_s) begin
      rej_s = 1'b1;
    end else begin
      case (bus.conf_addr)
        ADDR_BASE: begin
          op_base_s = !tgt_busy_s;
          rej_s     = tgt_busy_s;
        end
        ADDR_SIZE: begin
          op_size_s = !tgt_busy_s;
          rej_s     = tgt_busy_s;
        end
        ADDR_FIRE: begin
          op_fire_s = !tgt_busy_s && !tgt_size0_s;
          rej_s     = tgt_busy_s || tgt_size0_s;
        end
`ifdef MEM_CTRL_ABORT_EN
        ADDR_ABORT: begin
          op_abort_s = 1'b1;
          rej_s      = 1'b0;
        end
`endif
        default: rej_s = 1'b1;
      endcase
    end
  end

  // Round-robin pick of the next eligible channel after the last grant.
  always_comb begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      busy_s[i] = (state_q[i] == S_REQ);
      elig_s[i] = (state_q[i] == S_REQ) && (iss_q[i] != lines_q[i]) && !abort_pend_q[i]
                  && !(op_abort_s && (bus.conf_chan == CHAN_W'(i)));
    end
    grant_vld_s = 1'b0;
    grant_s     = '0;
    idx_s       = '0;
    // Walk from farthest to nearest so the nearest eligible channel wins.
    for (int k = NUM_CHAN; k >= 1; k--) begin
      idx_s       = CHAN_W'((int'(rr_q) + k) % NUM_CHAN);
      grant_s     = elig_s[idx_s] ? idx_s : grant_s;
      grant_vld_s = grant_vld_s | elig_s[idx_s];
    end
    accept_s = valid_q && bus.load_req_ready;
    issue_s  = grant_vld_s && (!valid_q || bus.load_req_ready);
  end

  // Channel FSMs, arbiter pointer and the registered request/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        state_q[i] <= S_IDLE;
        base_q[i]  <= '0;
        ptr_q[i]   <= '0;
        size_q[i]  <= '0;
        lines_q[i] <= '0;
        iss_q[i]   <= '0;
      end
      abort_pend_q <= '0;
      done_q       <= '0;
      rr_q         <= '0;
      chan_q       <= '0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      conf_err_q   <= 1'b0;
    end else begin
      conf_err_q <= rej_s;
      done_q     <= '0;
      if (issue_s) begin
        valid_q <= 1'b1;
        addr_q  <= ptr_q[grant_s];
        chan_q  <= grant_s;
        rr_q    <= grant_s;
        last_q  <= ((iss_q[grant_s] + CNT_W'(1)) == lines_q[grant_s]);
      end else if (accept_s) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end
      for (int i = 0; i < NUM_CHAN; i++) begin
        case (state_q[i])
          S_IDLE: begin
            if (op_base_s && (bus.conf_chan == CHAN_W'(i))) begin
              base_q[i] <= base_in_s;
            end
            if (op_size_s && (bus.conf_chan == CHAN_W'(i))) begin
              size_q[i] <= bus.conf_data[SIZE_W-1:0];
            end
            if (op_fire_s && (bus.conf_chan == CHAN_W'(i))) begin
              state_q[i] <= S_REQ;
              iss_q[i]   <= '0;
              lines_q[i] <= line_count(size_q[i]);
              ptr_q[i]   <= base_q[i];
            end
          end
          S_REQ: begin
            if (issue_s && (grant_s == CHAN_W'(i))) begin
              iss_q[i] <= iss_q[i] + CNT_W'(1);
              ptr_q[i] <= ptr_q[i] + ADDR_W'(LINE_BYTES);
            end
            if (accept_s && (chan_q == CHAN_W'(i)) && (last_q || abort_pend_q[i])) begin
              state_q[i]      <= S_IDLE;
              abort_pend_q[i] <= 1'b0;
              done_q[i]       <= !abort_pend_q[i];
            end
            // An abort hitting the presented request waits for its handshake.
            if (op_abort_s && (bus.conf_chan == CHAN_W'(i))) begin
              if (valid_q && (chan_q == CHAN_W'(i)) && !accept_s) begin
                abort_pend_q[i] <= 1'b1;
              end else begin
                state_q[i]      <= S_IDLE;
                abort_pend_q[i] <= 1'b0;
                done_q[i]       <= 1'b0;
              end
            end
          end
          default: state_q[i] <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.conf_err       = conf_err_q;
  assign bus.load_req_valid = valid_q;
  assign bus.load_req_addr  = addr_q;
  assign bus.load_req_chan  = chan_q;
  assign bus.chan_busy      = busy_s;
  assign bus.chan_done      = done_q;
endmodule

// File: tb/tb_mem_ctrl_mc.sv
// Directed-vector bench for mem_ctrl_mc; expected request streams are hand-computed.
// The abort scenario is compiled in when MEM_CTRL_ABORT_EN is defined.
module tb_mem_ctrl_mc;
  localparam int NUM_CHAN = 2;
  localparam int ADDR_W   = 64;
  localparam int CHAN_W   = 1;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   done_cnt [NUM_CHAN];
  logic [63:0] got_addr [$];
  int          got_chan [$];
  logic [63:0] exp_addr [$];
  int          exp_chan [$];

  mem_ctrl_mc_if #(.NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W)) bus ();

  mem_ctrl_mc #(.NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W), .SIZE_W(32), .LINE_BYTES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic conf_wr(input int ch, input logic [7:0] a, input logic [63:0] d,
                         input logic exp_err, input string tag);
    @(negedge clk);
    bus.conf_valid = 1'b1;
    bus.conf_chan  = CHAN_W'(ch);
    bus.conf_addr  = a;
    bus.conf_data  = d;
    @(negedge clk);
    bus.conf_valid = 1'b0;
    check_vec(tag, 64'(bus.conf_err), 64'(exp_err));
  endtask

  task automatic wait_valid(input string tag);
    for (int c = 0; c < 20 && !bus.load_req_valid; c++) @(negedge clk);
    check_vec(tag, 64'(bus.load_req_valid), 64'd1);
  endtask

  // Called at a negedge: records accepted requests and done pulses for n cycles.
  task automatic collect(input int n);
    got_addr.delete();
    got_chan.delete();
    for (int j = 0; j < NUM_CHAN; j++) done_cnt[j] = 0;
    for (int c = 0; c < n; c++) begin
      if (bus.load_req_valid && bus.load_req_ready) begin
        got_addr.push_back(bus.load_req_addr);
        got_chan.push_back(int'(bus.load_req_chan));
      end
      for (int j = 0; j < NUM_CHAN; j++) done_cnt[j] += int'(bus.chan_done[j]);
      @(negedge clk);
    end
  endtask

  task automatic cmp_reqs(input string tag);
    logic [63:0] a;
    logic [63:0] ch;
    check_vec({tag, "_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        a  = got_addr[i];
        ch = 64'(got_chan[i]);
      end else begin
        a  = 'x;
        ch = 'x;
      end
      check_vec($sformatf("%s_addr%0d", tag, i), a, exp_addr[i]);
      check_vec($sformatf("%s_chan%0d", tag, i), ch, 64'(exp_chan[i]));
    end
    exp_addr.delete();
    exp_chan.delete();
  endtask

  task automatic expect_req(input int ch, input logic [63:0] a);
    exp_chan.push_back(ch);
    exp_addr.push_back(a);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.conf_valid     = 1'b0;
    bus.conf_chan      = '0;
    bus.conf_addr      = 8'h00;
    bus.conf_data      = 64'h0;
    bus.load_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("rst_valid", 64'(bus.load_req_valid), 64'd0);
    check_vec("rst_addr",  bus.load_req_addr, 64'h0);
    check_vec("rst_chan",  64'(bus.load_req_chan), 64'd0);
    check_vec("rst_busy",  64'(bus.chan_busy), 64'd0);
    check_vec("rst_done",  64'(bus.chan_done), 64'd0);
    check_vec("rst_err",   64'(bus.conf_err), 64'd0);

    // Single channel, four lines.
    bus.load_req_ready = 1'b1;
    conf_wr(0, 8'h00, 64'h1000, 1'b0, "t1_base");
    conf_wr(0, 8'h08, 64'h100,  1'b0, "t1_size");
    conf_wr(0, 8'h10, 64'h0,    1'b0, "t1_fire");
    check_vec("t1_busy", 64'(bus.chan_busy), 64'd1);
    collect(12);
    expect_req(0, 64'h1000);
    expect_req(0, 64'h1040);
    expect_req(0, 64'h1080);
    expect_req(0, 64'h10C0);
    cmp_reqs("t1");
    check_vec("t1_done0", 64'(done_cnt[0]), 64'd1);
    check_vec("t1_idle", 64'(bus.chan_busy), 64'd0);

    // Two channels, stall with ready low, then alternating grants.
    bus.load_req_ready = 1'b0;
    conf_wr(0, 8'h00, 64'h2000, 1'b0, "t2_base0");
    conf_wr(0, 8'h08, 64'h80,   1'b0, "t2_size0");
    conf_wr(1, 8'h00, 64'h3000, 1'b0, "t2_base1");
    conf_wr(1, 8'h08, 64'h80,   1'b0, "t2_size1");
    conf_wr(0, 8'h10, 64'h0,    1'b0, "t2_fire0");
    conf_wr(1, 8'h10, 64'h0,    1'b0, "t2_fire1");
    wait_valid("t2_wait");
    for (int c = 0; c < 5; c++) begin
      check_vec($sformatf("t2_hold_valid%0d", c), 64'(bus.load_req_valid), 64'd1);
      check_vec($sformatf("t2_hold_addr%0d", c), bus.load_req_addr, 64'h2000);
      check_vec($sformatf("t2_hold_chan%0d", c), 64'(bus.load_req_chan), 64'd0);
      @(negedge clk);
    end
    check_vec("t2_busy", 64'(bus.chan_busy), 64'd3);
    bus.load_req_ready = 1'b1;
    collect(10);
    expect_req(0, 64'h2000);
    expect_req(1, 64'h3000);
    expect_req(0, 64'h2040);
    expect_req(1, 64'h3040);
    cmp_reqs("t2");
    check_vec("t2_done0", 64'(done_cnt[0]), 64'd1);
    check_vec("t2_done1", 64'(done_cnt[1]), 64'd1);

    // Rejected writes leave registers untouched.
    bus.load_req_ready = 1'b0;
    conf_wr(1, 8'h00, 64'h5000, 1'b0, "t3_base1");
    conf_wr(1, 8'h08, 64'h40,   1'b0, "t3_size1");
    conf_wr(1, 8'h10, 64'h0,    1'b0, "t3_fire1");
    conf_wr(1, 8'h00, 64'h9900, 1'b1, "t3_base_busy");
    conf_wr(1, 8'h08, 64'h400,  1'b1, "t3_size_busy");
    conf_wr(1, 8'h10, 64'h0,    1'b1, "t3_fire_busy");
    conf_wr(0, 8'h08, 64'h0,    1'b0, "t3_size_zero");
    conf_wr(0, 8'h10, 64'h0,    1'b1, "t3_fire_zero");
    conf_wr(0, 8'h20, 64'h1234, 1'b1, "t3_unmapped");
`ifdef MEM_CTRL_ABORT_EN
    conf_wr(0, 8'h18, 64'h0,    1'b0, "t3_abort_idle");
`else
    conf_wr(0, 8'h18, 64'h0,    1'b1, "t3_abort_unmapped");
`endif
    check_vec("t3_busy", 64'(bus.chan_busy), 64'd2);
    bus.load_req_ready = 1'b1;
    collect(6);
    expect_req(1, 64'h5000);
    cmp_reqs("t3");
    conf_wr(1, 8'h10, 64'h0, 1'b0, "t3_refire");
    collect(6);
    expect_req(1, 64'h5000);
    cmp_reqs("t3_replay");
    check_vec("t3_replay_done1", 64'(done_cnt[1]), 64'd1);

    // Unaligned base and partial last line, then a replay.
    conf_wr(0, 8'h00, 64'h1041, 1'b0, "t4_base");
    conf_wr(0, 8'h08, 64'h41,   1'b0, "t4_size");
    conf_wr(0, 8'h10, 64'h0,    1'b0, "t4_fire");
    collect(8);
    expect_req(0, 64'h1040);
    expect_req(0, 64'h1080);
    cmp_reqs("t4");
    conf_wr(0, 8'h10, 64'h0, 1'b0, "t4_refire");
    collect(8);
    expect_req(0, 64'h1040);
    expect_req(0, 64'h1080);
    cmp_reqs("t4_replay");
    check_vec("t4_done0", 64'(done_cnt[0]), 64'd1);

    // FIRE landing on the cycle of the last acceptance is rejected.
    conf_wr(0, 8'h08, 64'h40, 1'b0, "t5_size");
    conf_wr(0, 8'h10, 64'h0,  1'b0, "t5_fire");
    conf_wr(0, 8'h10, 64'h0,  1'b1, "t5_fire_on_last");
    check_vec("t5_done0", 64'(bus.chan_done), 64'd1);
    collect(6);
    check_vec("t5_no_restart", 64'(got_addr.size()), 64'd0);

`ifdef MEM_CTRL_ABORT_EN
    // Abort of a presented request completes its handshake, then stops quietly.
    bus.load_req_ready = 1'b0;
    conf_wr(0, 8'h00, 64'h7000, 1'b0, "t6_base");
    conf_wr(0, 8'h08, 64'h100,  1'b0, "t6_size");
    conf_wr(0, 8'h10, 64'h0,    1'b0, "t6_fire");
    wait_valid("t6_wait");
    conf_wr(0, 8'h18, 64'h0, 1'b0, "t6_abort");
    check_vec("t6_held_valid", 64'(bus.load_req_valid), 64'd1);
    check_vec("t6_held_addr", bus.load_req_addr, 64'h7000);
    bus.load_req_ready = 1'b1;
    collect(8);
    expect_req(0, 64'h7000);
    cmp_reqs("t6");
    check_vec("t6_no_done", 64'(done_cnt[0]), 64'd0);
    check_vec("t6_busy", 64'(bus.chan_busy), 64'd0);
`endif

    // Reset in the middle of a transfer.
    bus.load_req_ready = 1'b0;
    conf_wr(0, 8'h00, 64'h8000, 1'b0, "t7_base");
    conf_wr(0, 8'h08, 64'h100,  1'b0, "t7_size");
    conf_wr(0, 8'h10, 64'h0,    1'b0, "t7_fire");
    wait_valid("t7_wait");
    rst_n = 1'b0;
    #1;
    check_vec("t7_valid", 64'(bus.load_req_valid), 64'd0);
    check_vec("t7_addr",  bus.load_req_addr, 64'h0);
    check_vec("t7_busy",  64'(bus.chan_busy), 64'd0);
    check_vec("t7_done",  64'(bus.chan_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.load_req_ready = 1'b1;
    collect(4);
    check_vec("t7_no_req", 64'(got_addr.size()), 64'd0);
    check_vec("t7_no_done", 64'(done_cnt[0]), 64'd0);
    conf_wr(0, 8'h10, 64'h0, 1'b1, "t7_size_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
